// File: rtl/kbd_fifo_port.sv
// kbd_fifo_port
//   Memory-mapped keyboard byte buffer on the CPU's 8-bit bus. Bytes from the
//   PS/2 decoder enter a small FIFO; software reads the head through a 4-byte
//   register window and pops it with an explicit write. O_IRQ is a toggle line:
//   every level change is one interrupt request.
//
//   Register window (offset = I_ADDR[1:0]):
//     +0 DATA  R   FIFO head byte, 8'h00 when empty (no read side effects)
//     +1 STAT  R   {OVF, FULL, 2'b00, count[3:0]}
//              W   bit0 POP, bit1 CLEAR, bit7 clear OVF
//     +2 CTRL  R/W bit0 IE
//     +3 reserved, reads 8'h00
//
// Parameters:
//   BASE        window base address (low 2 bits ignored)
//   DEPTH_LOG2  FIFO depth = 2**DEPTH_LOG2
//
// Ports:
//   CLOCK, RESET_N        clock, asynchronous active-low reset
//   I_ADDR/I_DATA/I_WREN  CPU bus address, write data, write enable
//   O_DATA/O_HIT          combinational read data and window hit
//   I_KVALID/I_KDATA      one-cycle byte strobe from the PS/2 decoder
//   O_IRQ                 toggle-style interrupt request
//
// Build option:
//   KBD_FIFO_LOOPBACK_EN  when defined, a CPU write to +0 pushes I_DATA into
//                         the FIFO ahead of any keyboard byte in that cycle.

module kbd_fifo_port #(
    parameter logic [15:0] BASE       = 16'hFF00,
    parameter int          DEPTH_LOG2 = 3
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [15:0] I_ADDR,
    input  logic [7:0]  I_DATA,
    input  logic        I_WREN,
    output logic [7:0]  O_DATA,
    output logic        O_HIT,
    input  logic        I_KVALID,
    input  logic [7:0]  I_KDATA,
    output logic        O_IRQ
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  ie_q, ie_d;
    logic                  irq_q, irq_d;

    logic [1:0]            off;
    logic                  wr_en;
    logic                  pop_req, clear_req, ovf_clr_req, ctrl_wr;
    logic                  cpu_push_req;
    logic                  do_pop;
    logic [CW-1:0]         free;
    logic                  cpu_ok, kbd_ok, drop;
    logic [1:0]            n_push;
    logic                  eff_push, eff_pop;
    logic                  irq_evt, ie_rise_evt;
    logic [DEPTH_LOG2-1:0] wp;
    logic                  full;
    logic [3:0]            cnt4;
    logic [7:0]            rd_data;

`ifndef KBD_FIFO_LOOPBACK_EN
    // Data bits 2..6 only carry payload in the loopback build.
    logic unused_wdata;
    assign unused_wdata = ^I_DATA[6:2];
`endif

    // Bus decode and write-request qualification.
    always_comb begin
        O_HIT       = (I_ADDR[15:2] == BASE[15:2]);
        off         = I_ADDR[1:0];
        wr_en       = I_WREN && O_HIT;
        pop_req     = wr_en && (off == 2'd1) && I_DATA[0];
        clear_req   = wr_en && (off == 2'd1) && I_DATA[1];
        ovf_clr_req = wr_en && (off == 2'd1) && I_DATA[7];
        ctrl_wr     = wr_en && (off == 2'd2);
`ifdef KBD_FIFO_LOOPBACK_EN
        cpu_push_req = wr_en && (off == 2'd0);
`else
        cpu_push_req = 1'b0;
`endif
    end

    // Next-state logic for the FIFO, flags and interrupt toggle.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        ie_d     = ie_q;
        irq_d    = irq_q;
        wp       = wr_ptr_q;

        do_pop = pop_req && (count_q != '0);

        // A pop in the same cycle frees a slot for an incoming byte.
        free = CW'(DEPTH) - count_q + CW'(do_pop);

        // CPU loopback byte is stored first; the keyboard byte needs the next slot.
        cpu_ok = cpu_push_req && (free != '0);
        kbd_ok = I_KVALID && (cpu_ok ? (free > CW'(1)) : (free != '0));
        n_push = {1'b0, cpu_ok} + {1'b0, kbd_ok};

        // Bytes discarded by CLEAR are not overflow.
        drop = !clear_req && ((I_KVALID && !kbd_ok) || (cpu_push_req && !cpu_ok));

        if (clear_req) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (cpu_ok) begin
                mem_d[wp] = I_DATA;
                wp        = wp + 1'b1;
            end
            if (kbd_ok) begin
                mem_d[wp] = I_KDATA;
                wp        = wp + 1'b1;
            end
            wr_ptr_d = wp;
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(do_pop);
            count_d  = count_q + CW'(n_push) - CW'(do_pop);
        end

        // Overflow set has priority over a software clear in the same cycle.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_req) begin
            ovf_d = 1'b0;
        end

        if (ctrl_wr) begin
            ie_d = I_DATA[0];
        end

        eff_push = !clear_req && (n_push != 2'd0);
        eff_pop  = !clear_req && do_pop;

        // Push into empty announces the first byte; a pop that leaves data
        // behind re-arms the request for the next byte. Push+pop is silent.
        irq_evt = ie_q && ((eff_push && !eff_pop && (count_q == '0)) ||
                           (eff_pop && !eff_push && (count_q > CW'(1))));

        // Enabling interrupts with data already buffered must not lose it.
        ie_rise_evt = ie_d && !ie_q && (count_d != '0);

        irq_d = irq_q ^ (irq_evt || ie_rise_evt);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ie_q     <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ie_q     <= ie_d;
            irq_q    <= irq_d;
        end
    end

    // Zero-latency read path, muxed into the CPU read bus with O_HIT.
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        cnt4    = 4'(count_q);
        rd_data = 8'h00;
        case (off)
            2'd0: if (count_q != '0) rd_data = mem_q[rd_ptr_q];
            2'd1: rd_data = {ovf_q, full, 2'b00, cnt4};
            2'd2: rd_data = {7'b0000000, ie_q};
            default: rd_data = 8'h00;
        endcase
        O_DATA = O_HIT ? rd_data : 8'h00;
    end

    assign O_IRQ = irq_q;

endmodule

// File: tb/tb_kbd_fifo_port.sv
module tb_kbd_fifo_port;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        CLOCK;
    logic        RESET_N;
    logic [15:0] I_ADDR;
    logic [7:0]  I_DATA;
    logic        I_WREN;
    logic [7:0]  O_DATA;
    logic        O_HIT;
    logic        I_KVALID;
    logic [7:0]  I_KDATA;
    logic        O_IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    kbd_fifo_port #(.BASE(BASE), .DEPTH_LOG2(3)) dut (
        .CLOCK    (CLOCK),
        .RESET_N  (RESET_N),
        .I_ADDR   (I_ADDR),
        .I_DATA   (I_DATA),
        .I_WREN   (I_WREN),
        .O_DATA   (O_DATA),
        .O_HIT    (O_HIT),
        .I_KVALID (I_KVALID),
        .I_KDATA  (I_KDATA),
        .O_IRQ    (O_IRQ)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic cyc();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        I_ADDR   = 16'h0000;
        I_DATA   = 8'h00;
        I_WREN   = 1'b0;
        I_KVALID = 1'b0;
        I_KDATA  = 8'h00;
        RESET_N  = 1'b0;
        cyc();
        cyc();
        RESET_N = 1'b1;
        cyc();
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [7:0] d);
        I_ADDR = BASE + {14'd0, off};
        I_DATA = d;
        I_WREN = 1'b1;
        cyc();
        I_WREN = 1'b0;
        I_DATA = 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        I_KVALID = 1'b1;
        I_KDATA  = b;
        cyc();
        I_KVALID = 1'b0;
    endtask

    task automatic rd(input logic [1:0] off, output logic [7:0] v);
        I_ADDR = BASE + {14'd0, off};
        #1;
        v = O_DATA;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        do_reset();
        n_checks++;
        if (O_IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", O_IRQ); end
        rd(2'd1, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_stat got=%h exp=00", v); end
        rd(2'd0, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", v); end
        rd(2'd2, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=00", v); end
        // Write to an address just outside the window must not reach CTRL.
        I_ADDR = 16'hFF06; I_DATA = 8'h01; I_WREN = 1'b1;
        #1;
        n_checks++;
        if (O_HIT !== 1'b0 || O_DATA !== 8'h00) begin
            n_fail++; $display("FAIL miss_addr hit=%b data=%h exp hit=0 data=00", O_HIT, O_DATA);
        end
        cyc();
        I_WREN = 1'b0;
        rd(2'd2, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL miss_write_ctrl got=%h exp=00", v); end
        rd(2'd3, v);
        n_checks++;
        if (v !== 8'h00 || O_HIT !== 1'b1) begin
            n_fail++; $display("FAIL reserved got=%h hit=%b exp=00 hit=1", v, O_HIT);
        end
    endtask

    task automatic test_first_byte();
        logic [7:0] v;
        do_reset();
        bus_write(2'd2, 8'h01);
        rd(2'd2, v);
        n_checks++;
        if (v !== 8'h01) begin n_fail++; $display("FAIL ctrl_ie got=%h exp=01", v); end
        n_checks++;
        if (O_IRQ !== 1'b0) begin n_fail++; $display("FAIL ie_empty_irq got=%b exp=0", O_IRQ); end
        push(8'h1C);
        rd(2'd1, v);
        n_checks++;
        if (v !== 8'h01) begin n_fail++; $display("FAIL first_stat got=%h exp=01", v); end
        rd(2'd0, v);
        n_checks++;
        if (v !== 8'h1C) begin n_fail++; $display("FAIL first_data got=%h exp=1C", v); end
        n_checks++;
        if (O_IRQ !== 1'b1) begin n_fail++; $display("FAIL first_irq got=%b exp=1", O_IRQ); end
        cyc();
        cyc();
        cyc();
        n_checks++;
        if (O_IRQ !== 1'b1) begin n_fail++; $display("FAIL first_irq_once got=%b exp=1", O_IRQ); end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        do_reset();
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        rd(2'd1, v);
        n_checks++;
        if (v !== 8'h48) begin n_fail++; $display("FAIL full_stat got=%h exp=48", v); end
        push(8'h18);
        rd(2'd1, v);
        n_checks++;
        if (v !== 8'hC8) begin n_fail++; $display("FAIL ovf_stat got=%h exp=C8", v); end
        // Push while full plus clear-OVF in the same cycle: set wins.
        I_KVALID = 1'b1; I_KDATA = 8'h19;
        bus_write(2'd1, 8'h80);
        I_KVALID = 1'b0;
        rd(2'd1, v);
        n_checks++;
        if (v !== 8'hC8) begin n_fail++; $display("FAIL ovf_set_wins got=%h exp=C8", v); end
        for (int i = 0; i < 8; i++) begin
            rd(2'd0, v);
            n_checks++;
            if (v !== 8'h10 + 8'(i)) begin
                n_fail++; $display("FAIL ovf_pop_data idx=%0d got=%h exp=%h", i, v, 8'h10 + 8'(i));
            end
            bus_write(2'd1, 8'h01);
        end
        rd(2'd1, v);
        n_checks++;
        if (v !== 8'h80) begin n_fail++; $display("FAIL drained_stat got=%h exp=80", v); end
        rd(2'd0, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL drained_data got=%h exp=00", v); end
        bus_write(2'd1, 8'h80);
        rd(2'd1, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL ovf_clear got=%h exp=00", v); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] v;
        do_reset();
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        I_KVALID = 1'b1; I_KDATA = 8'hAA;
        bus_write(2'd1, 8'h01);
        I_KVALID = 1'b0;
        rd(2'd1, v);
        n_checks++;
        if (v !== 8'h48) begin n_fail++; $display("FAIL pushpop_stat got=%h exp=48", v); end
        // The concurrent pop was pop 1; six more reach 8'h17, a seventh 8'hAA.
        for (int i = 0; i < 6; i++) bus_write(2'd1, 8'h01);
        rd(2'd0, v);
        n_checks++;
        if (v !== 8'h17) begin n_fail++; $display("FAIL pushpop_7th got=%h exp=17", v); end
        bus_write(2'd1, 8'h01);
        rd(2'd0, v);
        n_checks++;
        if (v !== 8'hAA) begin n_fail++; $display("FAIL pushpop_8th got=%h exp=AA", v); end
        rd(2'd1, v);
        n_checks++;
        if (v !== 8'h01) begin n_fail++; $display("FAIL pushpop_last_stat got=%h exp=01", v); end
    endtask

    task automatic test_irq_pops();
        logic [7:0] v;
        do_reset();
        bus_write(2'd2, 8'h01);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        n_checks++;
        if (O_IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_after_push got=%b exp=1", O_IRQ); end
        bus_write(2'd1, 8'h01);
        n_checks++;
        if (O_IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_pop1 got=%b exp=0", O_IRQ); end
        bus_write(2'd1, 8'h01);
        n_checks++;
        if (O_IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_pop2 got=%b exp=1", O_IRQ); end
        bus_write(2'd1, 8'h01);
        n_checks++;
        if (O_IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_pop3 got=%b exp=1", O_IRQ); end
        bus_write(2'd1, 8'h01);
        rd(2'd1, v);
        n_checks++;
        if (v !== 8'h00 || O_IRQ !== 1'b1) begin
            n_fail++; $display("FAIL pop_empty stat=%h irq=%b exp stat=00 irq=1", v, O_IRQ);
        end
    endtask

    task automatic test_clear();
        logic [7:0] v;
        do_reset();
        bus_write(2'd2, 8'h01);
        push(8'h01);
        push(8'h02);
        I_KVALID = 1'b1; I_KDATA = 8'h55;
        bus_write(2'd1, 8'h02);
        I_KVALID = 1'b0;
        rd(2'd1, v);
        n_checks++;
        if (v !== 8'h00 || O_IRQ !== 1'b1) begin
            n_fail++; $display("FAIL clear_stat stat=%h irq=%b exp stat=00 irq=1", v, O_IRQ);
        end
        // CLEAR on an empty FIFO with a byte arriving: no push-into-empty request.
        I_KVALID = 1'b1; I_KDATA = 8'h55;
        bus_write(2'd1, 8'h02);
        I_KVALID = 1'b0;
        rd(2'd1, v);
        n_checks++;
        if (v !== 8'h00 || O_IRQ !== 1'b1) begin
            n_fail++; $display("FAIL clear_empty stat=%h irq=%b exp stat=00 irq=1", v, O_IRQ);
        end
        rd(2'd0, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL clear_data got=%h exp=00", v); end
    endtask

    task automatic test_ie_enable();
        logic [7:0] v;
        do_reset();
        push(8'h31);
        push(8'h32);
        n_checks++;
        if (O_IRQ !== 1'b0) begin n_fail++; $display("FAIL ie0_ignored got=%b exp=0", O_IRQ); end
        bus_write(2'd2, 8'h01);
        n_checks++;
        if (O_IRQ !== 1'b1) begin n_fail++; $display("FAIL ie_rise got=%b exp=1", O_IRQ); end
        cyc();
        cyc();
        n_checks++;
        if (O_IRQ !== 1'b1) begin n_fail++; $display("FAIL ie_rise_once got=%b exp=1", O_IRQ); end
        // Two-cycle store at STAT acts twice: both bytes popped.
        I_ADDR = BASE + 16'd1; I_DATA = 8'h01; I_WREN = 1'b1;
        cyc();
        cyc();
        I_WREN = 1'b0;
        rd(2'd1, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL double_pop got=%h exp=00", v); end
    endtask

    task automatic test_async_reset();
        logic [7:0] v;
        do_reset();
        bus_write(2'd2, 8'h01);
        push(8'h77);
        push(8'h78);
        @(posedge CLOCK);
        #3;
        RESET_N = 1'b0;
        #1;
        n_checks++;
        if (O_IRQ !== 1'b0) begin n_fail++; $display("FAIL async_irq got=%b exp=0", O_IRQ); end
        rd(2'd1, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL async_stat got=%h exp=00", v); end
        rd(2'd2, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL async_ctrl got=%h exp=00", v); end
        cyc();
        RESET_N = 1'b1;
        cyc();
    endtask

    task automatic test_loopback();
        logic [7:0] v;
        logic [7:0] exp_stat;
        logic [7:0] exp_data;
        do_reset();
        bus_write(2'd0, 8'h42);
`ifdef KBD_FIFO_LOOPBACK_EN
        exp_stat = 8'h01;
        exp_data = 8'h42;
`else
        exp_stat = 8'h00;
        exp_data = 8'h00;
`endif
        rd(2'd1, v);
        n_checks++;
        if (v !== exp_stat) begin n_fail++; $display("FAIL loopback_stat got=%h exp=%h", v, exp_stat); end
        rd(2'd0, v);
        n_checks++;
        if (v !== exp_data) begin n_fail++; $display("FAIL loopback_data got=%h exp=%h", v, exp_data); end
    endtask

    initial begin
        RESET_N  = 1'b0;
        I_ADDR   = 16'h0000;
        I_DATA   = 8'h00;
        I_WREN   = 1'b0;
        I_KVALID = 1'b0;
        I_KDATA  = 8'h00;
        test_reset();
        test_first_byte();
        test_overflow();
        test_full_push_pop();
        test_irq_pops();
        test_clear();
        test_ie_enable();
        test_async_reset();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
